// File: rtl/core_pkg.sv
// Shared core definitions: fetch FSM state encoding and register-file constants.
package core_pkg;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      WAIT    = 2'd1,
      DISCARD = 2'd2
   } fetch_state_t;

   localparam int REG_ADDR_W = 5;
   localparam int REG_X0     = 0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear beats increment).
// Sticks at all-ones instead of wrapping; async active-low reset to zero.
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] q
);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         q <= '0;
      end else if (clr) begin
         q <= '0;
      end else if (inc && (q != {W{1'b1}})) begin
         q <= q + W'(1);
      end
   end

endmodule

// File: rtl/fetch_hazard_ctrl.sv
// PC / IF-ID sequencing for the 5-stage core: load-use stalls, EX redirects,
// multi-cycle fetches and wrong-path fetch discard, plus stall/flush perf counters.
module fetch_hazard_ctrl #(
   parameter int CNT_W      = 32,
   parameter int REG_ADDR_W = core_pkg::REG_ADDR_W,
   parameter bit X0_FILTER  = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  imem_ready,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic                  ex_mem_read,
   input  logic [REG_ADDR_W-1:0] ex_rd,
   input  logic                  branch_taken,
   input  logic                  cnt_clr,
   output logic                  pc_write,
   output logic                  if_id_load,
   output logic                  if_id_flush,
   output logic                  id_ex_flush,
   output logic [CNT_W-1:0]      stall_cnt,
   output logic [CNT_W-1:0]      flush_cnt,
   output logic [1:0]            state_o
);
   import core_pkg::*;

   localparam logic [1:0] ST_RUN     = 2'(RUN);
   localparam logic [1:0] ST_WAIT    = 2'(WAIT);
   localparam logic [1:0] ST_DISCARD = 2'(DISCARD);

   logic [1:0] state;
   logic [1:0] next_state;
   logic       load_use;
   logic       rd_is_x0;
   logic       stall_inc;
   logic       flush_inc;

   assign rd_is_x0 = (ex_rd == REG_ADDR_W'(REG_X0));
   assign load_use = ex_mem_read && ((ex_rd == id_rs1) || (ex_rd == id_rs2))
                     && !(X0_FILTER && rd_is_x0);

   // Priority decoder; the unused encoding 3 falls through and behaves as RUN.
   always_comb begin
      pc_write    = 1'b0;
      if_id_load  = 1'b0;
      if_id_flush = 1'b0;
      id_ex_flush = 1'b0;
      stall_inc   = 1'b0;
      flush_inc   = 1'b0;
      next_state  = ST_RUN;
      if (!reset) begin
         if_id_flush = 1'b1;
         id_ex_flush = 1'b1;
      end else if (branch_taken) begin
         pc_write    = 1'b1;
         if_id_flush = 1'b1;
         id_ex_flush = 1'b1;
         flush_inc   = 1'b1;
         next_state  = imem_ready ? ST_RUN : ST_DISCARD;
      end else if (state == ST_DISCARD) begin
         if_id_flush = 1'b1;
         next_state  = imem_ready ? ST_RUN : ST_DISCARD;
      end else if (load_use) begin
         id_ex_flush = 1'b1;
         stall_inc   = 1'b1;
         next_state  = imem_ready ? ST_RUN : ST_WAIT;
      end else if (!imem_ready) begin
         // ID instruction moves on; a bubble follows it into IF/ID.
         if_id_flush = 1'b1;
         stall_inc   = 1'b1;
         next_state  = ST_WAIT;
      end else begin
         pc_write    = 1'b1;
         if_id_load  = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_RUN;
      end else begin
         state <= next_state;
      end
   end

   assign state_o = state;

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (cnt_clr),
      .inc   (stall_inc),
      .q     (stall_cnt)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (cnt_clr),
      .inc   (flush_inc),
      .q     (flush_cnt)
   );

endmodule
